// File: rtl/led_strip_monitor.sv
// APA102-style strip link monitor: finds start frames, decodes LED words, reports end frame.
// Latency: pulses 1 cycle after the 32nd bit's sample event; no backpressure (observe-only tap).
module led_strip_monitor #(
  parameter bit SAMPLE_EDGE = 1'b0,
  parameter int MAX_LEDS    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       led_clock,
  input  logic       led_data,
  input  logic       led_clock_enable,
  output logic       pixel_valid,
  output logic [7:0] pixel_index,
  output logic [4:0] pixel_brightness,
  output logic [7:0] pixel_blue,
  output logic [7:0] pixel_green,
  output logic [7:0] pixel_red,
  output logic       frame_done,
  output logic [7:0] led_count,
  output logic       header_error,
  output logic       busy
);

  localparam logic [7:0] IDX_MAX = 8'(MAX_LEDS);
  localparam logic [7:0] CNT_MAX = (MAX_LEDS >= 255) ? 8'd255 : 8'(MAX_LEDS + 1);

  typedef enum logic {HUNT, FRAME} state_t;

  state_t      state, state_next;
  logic [1:0]  clk_sync, data_sync, en_sync;
  logic        clk_prev;
  logic        edge_det;
  logic        sample, sample_bit;
  logic [5:0]  zero_run;
  logic [4:0]  bit_count;
  logic [31:0] shift_word;
  logic [31:0] word_full;
  logic [7:0]  led_index, pix_cnt;
  logic        start_det, word_done;
  logic        is_zero, is_ones, is_pix, is_err;

  // Index 1 of each sync pair is the stable, metastability-filtered copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync   <= '0;
      data_sync  <= '0;
      en_sync    <= '0;
      clk_prev   <= 1'b0;
      sample     <= 1'b0;
      sample_bit <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], led_clock};
      data_sync  <= {data_sync[0], led_data};
      en_sync    <= {en_sync[0], led_clock_enable};
      clk_prev   <= clk_sync[1];
      sample     <= edge_det & en_sync[1];
      sample_bit <= data_sync[1];
    end
  end

  assign edge_det  = SAMPLE_EDGE ? (clk_sync[1] & ~clk_prev) : (~clk_sync[1] & clk_prev);
  assign word_full = {shift_word[30:0], sample_bit};
  assign start_det = (state == HUNT) && sample && !sample_bit && (zero_run == 6'd31);
  assign word_done = (state == FRAME) && sample && (bit_count == 5'd31);
  assign is_zero   = (word_full == 32'h0000_0000);
  assign is_ones   = (word_full == 32'hFFFF_FFFF);
  assign is_pix    = (word_full[31:29] == 3'b111) && !is_ones;
  assign is_err    = !is_zero && !is_ones && !is_pix;

  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT:  if (start_det) state_next = FRAME;
      FRAME: if (word_done && (is_ones || is_err)) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    busy = (state == FRAME);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_run         <= '0;
      bit_count        <= '0;
      shift_word       <= '0;
      led_index        <= '0;
      pix_cnt          <= '0;
      pixel_valid      <= 1'b0;
      pixel_index      <= '0;
      pixel_brightness <= '0;
      pixel_blue       <= '0;
      pixel_green      <= '0;
      pixel_red        <= '0;
      frame_done       <= 1'b0;
      led_count        <= '0;
      header_error     <= 1'b0;
    end else begin
      pixel_valid  <= 1'b0;
      frame_done   <= 1'b0;
      header_error <= 1'b0;
      if (sample) shift_word <= word_full;
      if (state == HUNT) begin
        if (sample) begin
          zero_run <= (sample_bit || start_det) ? 6'd0 : zero_run + 6'd1;
        end
        if (start_det) begin
          bit_count <= '0;
          led_index <= '0;
          pix_cnt   <= '0;
        end
      end else if (sample) begin
        bit_count <= bit_count + 5'd1;
        if (bit_count == 5'd31) begin
          if (is_zero) begin
            led_index <= '0;
            pix_cnt   <= '0;
          end else if (is_ones) begin
            frame_done <= 1'b1;
            led_count  <= pix_cnt;
          end else if (is_pix) begin
            pixel_valid      <= 1'b1;
            pixel_index      <= led_index;
            pixel_brightness <= word_full[28:24];
            pixel_blue       <= word_full[23:16];
            pixel_green      <= word_full[15:8];
            pixel_red        <= word_full[7:0];
            if (led_index != IDX_MAX) led_index <= led_index + 8'd1;
            if (pix_cnt != CNT_MAX)   pix_cnt   <= pix_cnt + 8'd1;
          end else begin
            header_error <= 1'b1;
            zero_run     <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_strip_monitor.sv
// Directed bench for led_strip_monitor: bit-banged strip words, pulses captured by a monitor.
module tb_led_strip_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       led_clock = 1'b0;
  logic       led_data = 1'b0;
  logic       led_clock_enable = 1'b1;
  logic       pixel_valid;
  logic [7:0] pixel_index;
  logic [4:0] pixel_brightness;
  logic [7:0] pixel_blue, pixel_green, pixel_red;
  logic       frame_done;
  logic [7:0] led_count;
  logic       header_error;
  logic       busy;

  int total = 0;
  int passed = 0;

  logic [39:0] cap_q[$];
  int fd_n = 0;
  int he_n = 0;
  int busy_n = 0;

  int base_px, base_fd, base_he, base_busy;

  led_strip_monitor #(.SAMPLE_EDGE(1'b0), .MAX_LEDS(255)) dut (
    .clk(clk), .reset(reset), .led_clock(led_clock), .led_data(led_data),
    .led_clock_enable(led_clock_enable), .pixel_valid(pixel_valid),
    .pixel_index(pixel_index), .pixel_brightness(pixel_brightness),
    .pixel_blue(pixel_blue), .pixel_green(pixel_green), .pixel_red(pixel_red),
    .frame_done(frame_done), .led_count(led_count), .header_error(header_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Captured record: {3'b0, brightness, index, blue, green, red}
  always @(negedge clk) begin
    if (pixel_valid) cap_q.push_back({3'b0, pixel_brightness, pixel_index, pixel_blue, pixel_green, pixel_red});
    if (frame_done) fd_n++;
    if (header_error) he_n++;
    if (busy) busy_n++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [39:0] cap_at(input int k);
    return (cap_q.size() > k) ? cap_q[k] : 40'hFF_FFFF_FFFF;
  endfunction

  task automatic send_bit(input logic b);
    led_data = b;
    repeat (2) @(negedge clk);
    led_clock = 1'b1;
    repeat (4) @(negedge clk);
    led_clock = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic mark();
    base_px = cap_q.size();
    base_fd = fd_n;
    base_he = he_n;
    base_busy = busy_n;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {pixel_valid, frame_done, header_error, busy, led_count, pixel_index,
                            pixel_brightness, pixel_blue, pixel_green, pixel_red}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Three pixels then end frame
    mark();
    send_word(32'h0000_0000);
    settle();
    check("busy_after_start", busy, 1);
    send_word(32'hE300_00FF);
    send_word(32'hE300_FFFF);
    send_word(32'hE300_FF00);
    settle();
    check("busy_mid_frame", busy, 1);
    send_word(32'hFFFF_FFFF);
    settle();
    check("t1_pixel_count", cap_q.size() - base_px, 3);
    check("t1_pixel0", cap_at(base_px),     40'h03000000FF);
    check("t1_pixel1", cap_at(base_px + 1), 40'h030100FFFF);
    check("t1_pixel2", cap_at(base_px + 2), 40'h030200FF00);
    check("t1_frame_done", fd_n - base_fd, 1);
    check("t1_led_count", led_count, 3);
    check("t1_busy_low", busy, 0);
    check("t1_fields_held", {pixel_index, pixel_red, pixel_green, pixel_blue}, 32'h0200FF00);
    check("t1_no_error", he_n - base_he, 0);

    // Bad header, then a clean strip update
    mark();
    send_word(32'h0000_0000);
    send_word(32'h6300_00FF);
    settle();
    check("t2_header_error", he_n - base_he, 1);
    check("t2_no_pixel", cap_q.size() - base_px, 0);
    check("t2_busy_low", busy, 0);
    send_word(32'h0000_0000);
    send_word(32'hE311_2233);
    send_word(32'hFFFF_FFFF);
    settle();
    check("t2_recover_pixel", cap_at(base_px), 40'h0300112233);
    check("t2_recover_done", fd_n - base_fd, 1);
    check("t2_recover_count", led_count, 1);

    // Repeated start frame
    mark();
    send_word(32'h0000_0000);
    send_word(32'h0000_0000);
    send_word(32'hE101_0203);
    send_word(32'hFFFF_FFFF);
    settle();
    check("t3_pixel_count", cap_q.size() - base_px, 1);
    check("t3_pixel", cap_at(base_px), 40'h0100010203);
    check("t3_led_count", led_count, 1);

    // 31 zeros broken by a one must not start a frame
    mark();
    send_word(32'h0000_0001);
    settle();
    check("t4_no_start_busy", busy, 0);
    check("t4_no_start_busy_seen", busy_n - base_busy, 0);
    send_word(32'h0000_0000);
    send_word(32'hE512_3456);
    settle();
    check("t4_pixel", cap_at(base_px), 40'h0500123456);
    check("t4_pixel_count", cap_q.size() - base_px, 1);
    send_word(32'hFFFF_FFFF);
    settle();
    check("t4_led_count", led_count, 1);

    // Reset in the middle of a pixel word
    send_word(32'h0000_0000);
    for (int i = 31; i >= 16; i--) send_bit(1'b1);
    settle();
    mark();
    reset = 1'b1;
    @(negedge clk);
    check("t5_reset_outputs", {pixel_valid, frame_done, header_error, busy, led_count, pixel_index,
                               pixel_brightness, pixel_blue, pixel_green, pixel_red}, 64'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_no_pulses", (cap_q.size() - base_px) + (fd_n - base_fd) + (he_n - base_he), 0);
    send_word(32'h0000_0000);
    send_word(32'hFFAA_BBCC);
    send_word(32'hFFFF_FFFF);
    settle();
    check("t5_resend_pixel", cap_at(base_px), 40'h1F00AABBCC);
    check("t5_resend_done", fd_n - base_fd, 1);
    check("t5_resend_count", led_count, 1);

    // Clock edges ignored while the enable is low
    mark();
    led_clock_enable = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) send_bit(1'b0);
    settle();
    check("t6_busy_never", busy_n - base_busy, 0);
    check("t6_no_events", (cap_q.size() - base_px) + (fd_n - base_fd) + (he_n - base_he), 0);
    led_clock_enable = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/led_strip_monitor.md
# led_strip_monitor

Serial receiver for the APA102-style LED strip link: it samples the data/clock pair driven toward the strip and finds start frames (32 zero bits). It decodes each 32-bit LED frame (3-bit `111` header, 5-bit global brightness, B, G, R) and reports the end frame (32 one bits). It sits on the FPGA beside the strip driver in loopback, or on an input header tapping the strip wires. Its per-LED pixel stream drives the on-screen strip preview and the self-check logic.

## Interface
- `SAMPLE_EDGE`, 0, 0 = sample `led_data` on falling edge of `led_clock`, 1 = on rising edge
- `MAX_LEDS`, 255, LED index saturation value (≤ 255)
- `clk`  input  1  system clock; all logic in this domain
- `reset`  input  1  synchronous, active-high reset
- `led_clock`  input  1  strip serial clock, asynchronous to `clk`, at most clk/4
- `led_data`  input  1  strip serial data
- `led_clock_enable`  input  1  qualifies `led_clock` edges; edges are ignored while low
- `pixel_valid`  output  1  one-cycle pulse: pixel fields valid
- `pixel_index`  output  8  LED position since last start frame, 0-based
- `pixel_brightness`  output  5  global brightness field
- `pixel_blue`, `pixel_green`, `pixel_red`  output  8 each  colour fields
- `frame_done`  output  1  one-cycle pulse on end frame
- `led_count`  output  8  LEDs decoded in the completed strip update; held until next `frame_done`
- `header_error`  output  1  one-cycle pulse: frame word without `111` header
- `busy`  output  1  high from start-frame detection until end frame or error

## Operation
- Input conditioning: `led_clock`, `led_data` and `led_clock_enable` each pass through a 2-flop synchronizer. A registered copy of the synced clock gives edge detection. A sample event occurs on a cycle where the selected edge is detected and the synced enable is 1. That cycle captures the synced `led_data` bit.
- Bits arrive MSB first and are shifted into a 32-bit word register.
- State HUNT: a `zero_run` counter (6 bits) increments on each 0 sample and clears on each 1 sample. When the 32nd consecutive zero is sampled, go to FRAME with `bit_count`=0 and `pixel_index`=0, and assert `busy`.
- State FRAME: shift each sample and increment the 5-bit `bit_count`, which wraps 31→0. On the 32nd bit, classify the complete word W:
  - W == 32'h0000_0000: repeated start frame. Reset the LED index to 0 and stay in FRAME.
  - W == 32'hFFFF_FFFF: end frame. Pulse `frame_done`, load `led_count` with the LEDs decoded, clear `busy`, go to HUNT. All-ones is always the end frame, never a pixel.
  - W[31:29] == 3'b111 (any other W): pixel. Load `pixel_brightness`=W[28:24], `pixel_blue`=W[23:16], `pixel_green`=W[15:8], `pixel_red`=W[7:0], and `pixel_index`=current index. Pulse `pixel_valid`. The index increments and saturates at `MAX_LEDS`. Pixels past saturation keep reporting index `MAX_LEDS`.
  - Otherwise: pulse `header_error`, clear `busy`, go to HUNT with `zero_run`=0.
- Blank LED frames (`111_00011`, colour 0) are ordinary pixels.
- `led_count` counts pixel words since the last start frame and saturates at `MAX_LEDS`+1 clipped to 255.
- Reset: state HUNT, counters 0, all outputs 0. A reset mid-frame discards the partial word. No pulse is emitted for it.

## Timing
- Sample event: 3 `clk` cycles after the selected `led_clock` edge reaches the pin (2 sync + 1 edge register).
- `pixel_valid`, `frame_done` and `header_error` assert on the cycle after the 32nd bit's sample event. Each is exactly one cycle wide.
- Pixel fields and `pixel_index` are registered together with `pixel_valid` and hold until the next pixel.
- `busy` rises on the cycle after the 32nd zero's sample event. It falls in the same cycle `frame_done` or `header_error` asserts.
- The pulses are mutually exclusive. At most one classification occurs per 32 samples.
- With `SAMPLE_EDGE`=0 and the team strip driver, data is stable across the falling edge. `SAMPLE_EDGE`=1 is for external strips.

## Test plan
- Transmit 32 zeros, then pixels 0xE3_0000FF, 0xE3_00FFFF and 0xE3_00FF00, then 32 ones, each bit held 8 `clk` cycles. Required: three `pixel_valid` pulses with index 0,1,2, brightness 3, and (R,G,B) = (255,0,0), (255,255,0), (0,255,0). Then `frame_done` with `led_count`=3 and `busy` low.
- Start frame, then word 0x6300_00FF. Required: `header_error` pulse, no `pixel_valid`, state back to HUNT. A following clean start frame decodes normally.
- Two zero words, then one pixel, then the end frame. Required: pixel index 0, `led_count`=1.
- 31 zeros, one 1, then 32 zeros and a pixel. Required: no decode from the first run. The pixel decodes at index 0.
- Assert `reset` after 16 bits of a pixel. Required: all outputs 0 the next cycle, no pulses. Re-sending the full sequence decodes correctly.
- Toggle `led_clock` 64 times with `led_clock_enable`=0 and data 0. Required: `busy` stays 0, no events.
